riscv_mc_ctrl: RTL and testbench



---
 rtl/riscv_mc_ctrl_pkg.sv | 85 ++++++++
 rtl/riscv_mc_ctrl_decode.sv | 45 ++++
 rtl/riscv_mc_ctrl.sv | 270 +++++++++++++++++++++++++++
 tb/tb_riscv_mc_ctrl.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_mc_ctrl_pkg.sv
// Shared definitions for the multi-cycle RV32I control path.
// Holds the major opcode constants, the FSM state encoding, the decoded
// opcode class, and the select/cause codes driven onto the datapath.
package riscv_mc_ctrl_pkg;

  // RV32I major opcodes (IR[6:0])
  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_TRAP   = 3'd5
  } state_e;

  typedef enum logic [3:0] {
    CLS_OP      = 4'd0,
    CLS_OP_IMM  = 4'd1,
    CLS_LUI     = 4'd2,
    CLS_AUIPC   = 4'd3,
    CLS_LOAD    = 4'd4,
    CLS_STORE   = 4'd5,
    CLS_BRANCH  = 4'd6,
    CLS_JAL     = 4'd7,
    CLS_JALR    = 4'd8,
    CLS_FENCE   = 4'd9,
    CLS_SYSTEM  = 4'd10,
    CLS_ILLEGAL = 4'd11
  } op_class_e;

  // Immediate-generator format select
  localparam logic [2:0] IMM_NONE = 3'd0;
  localparam logic [2:0] IMM_I    = 3'd1;
  localparam logic [2:0] IMM_S    = 3'd2;
  localparam logic [2:0] IMM_B    = 3'd3;
  localparam logic [2:0] IMM_J    = 3'd4;
  localparam logic [2:0] IMM_U    = 3'd5;

  // ALU operand selects
  localparam logic [1:0] ALU_A_RS1  = 2'd0;
  localparam logic [1:0] ALU_A_PC   = 2'd1;
  localparam logic [1:0] ALU_A_ZERO = 2'd2;
  localparam logic       ALU_B_RS2  = 1'b0;
  localparam logic       ALU_B_IMM  = 1'b1;

  // Writeback source and next-PC source
  localparam logic [1:0] WB_ALU = 2'd0;
  localparam logic [1:0] WB_MEM = 2'd1;
  localparam logic [1:0] WB_PC4 = 2'd2;
  localparam logic       PC_SEL_PC4 = 1'b0;
  localparam logic       PC_SEL_ALU = 1'b1;

  // Trap causes
  localparam logic [1:0] CAUSE_NONE    = 2'd0;
  localparam logic [1:0] CAUSE_ILLEGAL = 2'd1;
  localparam logic [1:0] CAUSE_SYSTEM  = 2'd2;
  localparam logic [1:0] CAUSE_BUS     = 2'd3;

  // Immediate format implied by an opcode class
  function automatic logic [2:0] imm_fmt_of(input op_class_e cls);
    logic [2:0] fmt;
    case (cls)
      CLS_OP_IMM, CLS_LOAD, CLS_JALR: fmt = IMM_I;
      CLS_STORE:                      fmt = IMM_S;
      CLS_BRANCH:                     fmt = IMM_B;
      CLS_JAL:                        fmt = IMM_J;
      CLS_LUI, CLS_AUIPC:             fmt = IMM_U;
      default:                        fmt = IMM_NONE;
    endcase
    return fmt;
  endfunction

endpackage

// File: rtl/riscv_mc_ctrl_decode.sv
// Combinational major-opcode decoder, kept separate so a pipelined core can
// reuse it.
// Ports:
//   opcode    in  IR[6:0]
//   op_class  out opcode class
//   imm_fmt   out immediate format for the immediate generator
//   illegal   out opcode is not a supported RV32I major opcode
//   is_system out opcode is SYSTEM (ECALL/EBREAK/CSR), which this core traps on
module riscv_mc_decode
  import riscv_mc_ctrl_pkg::*;
(
  input  logic [6:0] opcode,
  output op_class_e  op_class,
  output logic [2:0] imm_fmt,
  output logic       illegal,
  output logic       is_system
);

  op_class_e cls_s;

  // Map the major opcode onto an instruction class
  always_comb begin
    cls_s = CLS_ILLEGAL;
    case (opcode)
      OPC_LUI:      cls_s = CLS_LUI;
      OPC_AUIPC:    cls_s = CLS_AUIPC;
      OPC_JAL:      cls_s = CLS_JAL;
      OPC_JALR:     cls_s = CLS_JALR;
      OPC_BRANCH:   cls_s = CLS_BRANCH;
      OPC_LOAD:     cls_s = CLS_LOAD;
      OPC_STORE:    cls_s = CLS_STORE;
      OPC_OP_IMM:   cls_s = CLS_OP_IMM;
      OPC_OP:       cls_s = CLS_OP;
      OPC_MISC_MEM: cls_s = CLS_FENCE;
      OPC_SYSTEM:   cls_s = CLS_SYSTEM;
      default:      cls_s = CLS_ILLEGAL;
    endcase
  end

  assign op_class  = cls_s;
  assign imm_fmt   = imm_fmt_of(cls_s);
  assign illegal   = (cls_s == CLS_ILLEGAL);
  assign is_system = (cls_s == CLS_SYSTEM);

endmodule

// File: rtl/riscv_mc_ctrl.sv
// Multi-cycle control FSM for an RV32I core with one shared memory port.
// Sequences FETCH -> DECODE -> EXEC -> (MEM) -> (WB) per instruction, traps on
// illegal/SYSTEM opcodes and on memory requests that wait too long, and counts
// retired instructions (one per PC update).
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   opcode            IR[6:0], valid from DECODE onward
//   br_taken          branch comparator result, used in EXEC
//   mem_ready         memory accepts/completes the request this cycle
//   mem_req/mem_we/mem_is_fetch  memory request, store, instruction fetch
//   ir_we, pc_we, pc_sel, rf_we  datapath write strobes and next-PC select
//   alu_a_sel, alu_b_sel, wb_sel, imm_fmt  datapath selects
//   trap, trap_cause  halted flag and reason
//   instret           retired-instruction count
//   state_o           current FSM state
module riscv_mc_ctrl
  import riscv_mc_ctrl_pkg::*;
#(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [6:0]  opcode,
  input  logic        br_taken,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic        mem_we,
  output logic        mem_is_fetch,
  output logic        ir_we,
  output logic        pc_we,
  output logic        pc_sel,
  output logic        rf_we,
  output logic [1:0]  alu_a_sel,
  output logic        alu_b_sel,
  output logic [1:0]  wb_sel,
  output logic [2:0]  imm_fmt,
  output logic        trap,
  output logic [1:0]  trap_cause,
  output logic [31:0] instret,
  output logic [2:0]  state_o
);

  localparam logic             TO_EN   = (TIMEOUT != 32'sd0);
  localparam logic [CNT_W-1:0] TO_LAST = (TIMEOUT == 32'sd0) ? {CNT_W{1'b0}}
                                                              : CNT_W'(TIMEOUT - 32'sd1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_e             state_q, state_d;
  logic [1:0]         cause_q, cause_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [31:0]        instret_q, instret_d;

  op_class_e          dec_cls_s;
  logic [2:0]         dec_imm_fmt_s;
  logic               dec_illegal_s;
  logic               dec_system_s;

  logic               mem_req_s, mem_we_s, mem_is_fetch_s, ir_we_s;
  logic               pc_we_s, pc_sel_s, rf_we_s, trap_s;
  logic [1:0]         alu_a_sel_s, wb_sel_s;
  logic               alu_b_sel_s;
  logic [2:0]         imm_fmt_s;
  logic               expire_s;

  riscv_mc_decode u_decode (
    .opcode    (opcode),
    .op_class  (dec_cls_s),
    .imm_fmt   (dec_imm_fmt_s),
    .illegal   (dec_illegal_s),
    .is_system (dec_system_s)
  );

  // This is the last permitted waiting cycle; mem_ready now still wins.
  assign expire_s = TO_EN && !mem_ready && (cnt_q == TO_LAST);

  // Next state, trap cause and per-state datapath controls
  always_comb begin
    state_d        = state_q;
    cause_d        = cause_q;
    mem_req_s      = 1'b0;
    mem_we_s       = 1'b0;
    mem_is_fetch_s = 1'b0;
    ir_we_s        = 1'b0;
    pc_we_s        = 1'b0;
    pc_sel_s       = PC_SEL_PC4;
    rf_we_s        = 1'b0;
    alu_a_sel_s    = ALU_A_RS1;
    alu_b_sel_s    = ALU_B_RS2;
    wb_sel_s       = WB_ALU;
    imm_fmt_s      = IMM_NONE;
    trap_s         = 1'b0;
    case (state_q)
      ST_FETCH: begin
        mem_req_s      = 1'b1;
        mem_is_fetch_s = 1'b1;
        if (mem_ready) begin
          ir_we_s = 1'b1;
          state_d = ST_DECODE;
        end else if (expire_s) begin
          state_d = ST_TRAP;
          cause_d = CAUSE_BUS;
        end else begin
          state_d = ST_FETCH;
        end
      end
      ST_DECODE: begin
        imm_fmt_s = dec_imm_fmt_s;
        if (dec_illegal_s) begin
          state_d = ST_TRAP;
          cause_d = CAUSE_ILLEGAL;
        end else if (dec_system_s) begin
          state_d = ST_TRAP;
          cause_d = CAUSE_SYSTEM;
        end else begin
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        // The datapath registers the ALU result here, so the operand selects
        // only matter in this state.
        imm_fmt_s = dec_imm_fmt_s;
        case (dec_cls_s)
          CLS_OP: begin
            alu_a_sel_s = ALU_A_RS1;
            alu_b_sel_s = ALU_B_RS2;
            state_d     = ST_WB;
          end
          CLS_OP_IMM, CLS_JALR: begin
            alu_a_sel_s = ALU_A_RS1;
            alu_b_sel_s = ALU_B_IMM;
            state_d     = ST_WB;
          end
          CLS_LUI: begin
            alu_a_sel_s = ALU_A_ZERO;
            alu_b_sel_s = ALU_B_IMM;
            state_d     = ST_WB;
          end
          CLS_AUIPC, CLS_JAL: begin
            alu_a_sel_s = ALU_A_PC;
            alu_b_sel_s = ALU_B_IMM;
            state_d     = ST_WB;
          end
          CLS_LOAD, CLS_STORE: begin
            alu_a_sel_s = ALU_A_RS1;
            alu_b_sel_s = ALU_B_IMM;
            state_d     = ST_MEM;
          end
          CLS_BRANCH: begin
            alu_a_sel_s = ALU_A_PC;
            alu_b_sel_s = ALU_B_IMM;
            pc_we_s     = 1'b1;
            pc_sel_s    = br_taken;
            state_d     = ST_FETCH;
          end
          CLS_FENCE: begin
            pc_we_s  = 1'b1;
            pc_sel_s = PC_SEL_PC4;
            state_d  = ST_FETCH;
          end
          default: begin
            // IR cannot change after DECODE; anything else here is corruption.
            state_d = ST_TRAP;
            cause_d = CAUSE_ILLEGAL;
          end
        endcase
      end
      ST_MEM: begin
        imm_fmt_s = dec_imm_fmt_s;
        mem_req_s = 1'b1;
        mem_we_s  = (dec_cls_s == CLS_STORE);
        if (mem_ready) begin
          if (dec_cls_s == CLS_STORE) begin
            pc_we_s  = 1'b1;
            pc_sel_s = PC_SEL_PC4;
            state_d  = ST_FETCH;
          end else begin
            state_d = ST_WB;
          end
        end else if (expire_s) begin
          state_d = ST_TRAP;
          cause_d = CAUSE_BUS;
        end else begin
          state_d = ST_MEM;
        end
      end
      ST_WB: begin
        imm_fmt_s = dec_imm_fmt_s;
        rf_we_s   = 1'b1;
        pc_we_s   = 1'b1;
        state_d   = ST_FETCH;
        case (dec_cls_s)
          CLS_JAL, CLS_JALR: begin
            wb_sel_s = WB_PC4;
            pc_sel_s = PC_SEL_ALU;
          end
          CLS_LOAD: begin
            wb_sel_s = WB_MEM;
            pc_sel_s = PC_SEL_PC4;
          end
          default: begin
            wb_sel_s = WB_ALU;
            pc_sel_s = PC_SEL_PC4;
          end
        endcase
      end
      ST_TRAP: begin
        trap_s  = 1'b1;
        state_d = ST_TRAP;
      end
      default: begin
        state_d = ST_FETCH;
      end
    endcase
  end

  // Wait-cycle counter: restarts on every state change, saturates at max
  always_comb begin
    if (state_d != state_q) begin
      cnt_d = {CNT_W{1'b0}};
    end else if (mem_req_s && !mem_ready && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_d = cnt_q;
    end
  end

  // One instruction retires with each PC update
  always_comb begin
    if (pc_we_s) begin
      instret_d = instret_q + 32'd1;
    end else begin
      instret_d = instret_q;
    end
  end

  // State, cause, wait counter and retire counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_FETCH;
      cause_q   <= CAUSE_NONE;
      cnt_q     <= {CNT_W{1'b0}};
      instret_q <= 32'd0;
    end else begin
      state_q   <= state_d;
      cause_q   <= cause_d;
      cnt_q     <= cnt_d;
      instret_q <= instret_d;
    end
  end

  // Gating with rst_n drops every strobe the moment reset asserts, even
  // though the reset state (FETCH) would otherwise request memory.
  assign mem_req      = rst_n & mem_req_s;
  assign mem_we       = rst_n & mem_we_s;
  assign mem_is_fetch = rst_n & mem_is_fetch_s;
  assign ir_we        = rst_n & ir_we_s;
  assign pc_we        = rst_n & pc_we_s;
  assign pc_sel       = rst_n & pc_sel_s;
  assign rf_we        = rst_n & rf_we_s;
  assign alu_a_sel    = rst_n ? alu_a_sel_s : 2'd0;
  assign alu_b_sel    = rst_n & alu_b_sel_s;
  assign wb_sel       = rst_n ? wb_sel_s : 2'd0;
  assign imm_fmt      = rst_n ? imm_fmt_s : 3'd0;
  assign trap         = rst_n & trap_s;
  assign trap_cause   = cause_q;
  assign instret      = instret_q;
  assign state_o      = state_q;

endmodule

// File: tb/tb_riscv_mc_ctrl.sv
module tb_riscv_mc_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [6:0]  opcode;
  logic        br_taken;
  logic        mem_ready;
  logic        mem_req, mem_we, mem_is_fetch, ir_we, pc_we, pc_sel, rf_we;
  logic [1:0]  alu_a_sel;
  logic        alu_b_sel;
  logic [1:0]  wb_sel;
  logic [2:0]  imm_fmt;
  logic        trap;
  logic [1:0]  trap_cause;
  logic [31:0] instret;
  logic [2:0]  state_o;

  int tests_run    = 0;
  int tests_failed = 0;

  localparam logic [6:0] OP_ADDI  = 7'b0010011;
  localparam logic [6:0] OP_LW    = 7'b0000011;
  localparam logic [6:0] OP_SW    = 7'b0100011;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_SYS   = 7'b1110011;
  localparam logic [6:0] OP_BAD   = 7'h7F;

  always #5 clk = ~clk;

  riscv_mc_ctrl #(.TIMEOUT(4), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .br_taken(br_taken),
    .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we),
    .mem_is_fetch(mem_is_fetch), .ir_we(ir_we), .pc_we(pc_we),
    .pc_sel(pc_sel), .rf_we(rf_we), .alu_a_sel(alu_a_sel),
    .alu_b_sel(alu_b_sel), .wb_sel(wb_sel), .imm_fmt(imm_fmt), .trap(trap),
    .trap_cause(trap_cause), .instret(instret), .state_o(state_o)
  );

  // Observed control vector: state, trap, cause, then every strobe/select
  logic [20:0] obs;
  assign obs = {state_o, trap, trap_cause, mem_req, mem_we, mem_is_fetch, ir_we,
                pc_we, pc_sel, rf_we, alu_a_sel, alu_b_sel, wb_sel, imm_fmt};

  // Builds an expected vector in the same field order as obs
  function automatic logic [20:0] ev(input int st, tr, tc, mreq, mwe, mfe, irwe,
                                     pcwe, pcsel, rfwe, a, b, wb, imm);
    return {st[2:0], tr[0], tc[1:0], mreq[0], mwe[0], mfe[0], irwe[0],
            pcwe[0], pcsel[0], rfwe[0], a[1:0], b[0], wb[1:0], imm[2:0]};
  endfunction

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0; mem_ready = 1'b0; br_taken = 1'b0;
    repeat (2) @(negedge clk);
    @(posedge clk); #2;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    #12;
    tests_run++;
    if (obs !== 21'd0 || instret !== 32'd0) begin
      tests_failed++;
      $display("FAIL reset_state obs=%h instret=%0d exp obs=0 instret=0", obs, instret);
    end
    @(posedge clk); #2;
    rst_n = 1'b1;
    @(negedge clk); mem_ready = 1'b0; #1;
    tests_run++;
    if (obs !== ev(0,0,0, 1,0,1,0,0,0,0, 0,0,0,0)) begin
      tests_failed++;
      $display("FAIL reset_first_fetch obs=%h exp=%h", obs, ev(0,0,0, 1,0,1,0,0,0,0, 0,0,0,0));
    end
  endtask

  task automatic test_addi();
    logic [20:0] exp_v [4];
    exp_v[0] = ev(0,0,0, 1,0,1,1,0,0,0, 0,0,0,0);
    exp_v[1] = ev(1,0,0, 0,0,0,0,0,0,0, 0,0,0,1);
    exp_v[2] = ev(2,0,0, 0,0,0,0,0,0,0, 0,1,0,1);
    exp_v[3] = ev(4,0,0, 0,0,0,0,1,0,1, 0,0,0,1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); opcode = OP_ADDI; mem_ready = 1'b1; #1;
      tests_run++;
      if (obs !== exp_v[i]) begin
        tests_failed++;
        $display("FAIL addi_cyc%0d obs=%h exp=%h", i, obs, exp_v[i]);
      end
    end
    @(posedge clk); #2;
    tests_run++;
    if (instret !== 32'd1 || state_o !== 3'd0) begin
      tests_failed++;
      $display("FAIL addi_retire instret=%0d state=%0d exp 1/0", instret, state_o);
    end
  endtask

  task automatic test_load_wait();
    logic [20:0] exp_v [7];
    logic        rdy   [7];
    rdy = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    exp_v[0] = ev(0,0,0, 1,0,1,1,0,0,0, 0,0,0,0);
    exp_v[1] = ev(1,0,0, 0,0,0,0,0,0,0, 0,0,0,1);
    exp_v[2] = ev(2,0,0, 0,0,0,0,0,0,0, 0,1,0,1);
    exp_v[3] = ev(3,0,0, 1,0,0,0,0,0,0, 0,0,0,1);
    exp_v[4] = ev(3,0,0, 1,0,0,0,0,0,0, 0,0,0,1);
    exp_v[5] = ev(3,0,0, 1,0,0,0,0,0,0, 0,0,0,1);
    exp_v[6] = ev(4,0,0, 0,0,0,0,1,0,1, 0,0,1,1);
    for (int i = 0; i < 7; i++) begin
      @(negedge clk); opcode = OP_LW; mem_ready = rdy[i]; #1;
      tests_run++;
      if (obs !== exp_v[i]) begin
        tests_failed++;
        $display("FAIL load_cyc%0d obs=%h exp=%h", i, obs, exp_v[i]);
      end
    end
    @(posedge clk); #2;
    tests_run++;
    if (instret !== 32'd2 || state_o !== 3'd0 || trap !== 1'b0) begin
      tests_failed++;
      $display("FAIL load_retire instret=%0d state=%0d trap=%b exp 2/0/0", instret, state_o, trap);
    end
  endtask

  task automatic test_branch();
    logic [20:0] exp_v [3];
    for (int k = 0; k < 2; k++) begin
      exp_v[0] = ev(0,0,0, 1,0,1,1,0,0,0, 0,0,0,0);
      exp_v[1] = ev(1,0,0, 0,0,0,0,0,0,0, 0,0,0,3);
      exp_v[2] = ev(2,0,0, 0,0,0,0,1,(k == 0) ? 1 : 0,0, 1,1,0,3);
      for (int i = 0; i < 3; i++) begin
        @(negedge clk); opcode = OP_BEQ; mem_ready = 1'b1; br_taken = (k == 0); #1;
        tests_run++;
        if (obs !== exp_v[i]) begin
          tests_failed++;
          $display("FAIL branch_taken%0d_cyc%0d obs=%h exp=%h", (k == 0), i, obs, exp_v[i]);
        end
      end
      @(posedge clk); #2;
      tests_run++;
      if (instret !== 32'(3 + k) || state_o !== 3'd0) begin
        tests_failed++;
        $display("FAIL branch_retire%0d instret=%0d state=%0d exp %0d/0", k, instret, state_o, 3 + k);
      end
    end
    br_taken = 1'b0;
  endtask

  task automatic test_jal();
    logic [20:0] exp_v [4];
    exp_v[0] = ev(0,0,0, 1,0,1,1,0,0,0, 0,0,0,0);
    exp_v[1] = ev(1,0,0, 0,0,0,0,0,0,0, 0,0,0,4);
    exp_v[2] = ev(2,0,0, 0,0,0,0,0,0,0, 1,1,0,4);
    exp_v[3] = ev(4,0,0, 0,0,0,0,1,1,1, 0,0,2,4);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); opcode = OP_JAL; mem_ready = 1'b1; #1;
      tests_run++;
      if (obs !== exp_v[i]) begin
        tests_failed++;
        $display("FAIL jal_cyc%0d obs=%h exp=%h", i, obs, exp_v[i]);
      end
    end
    @(posedge clk); #2;
    tests_run++;
    if (instret !== 32'd5) begin
      tests_failed++;
      $display("FAIL jal_retire instret=%0d exp 5", instret);
    end
  endtask

  task automatic test_illegal();
    @(negedge clk); opcode = OP_BAD; mem_ready = 1'b1; #1;
    @(negedge clk); #1;
    tests_run++;
    if (state_o !== 3'd1) begin
      tests_failed++;
      $display("FAIL illegal_decode state=%0d exp 1", state_o);
    end
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); #1;
      tests_run++;
      if (obs !== ev(5,1,1, 0,0,0,0,0,0,0, 0,0,0,0) || instret !== 32'd5) begin
        tests_failed++;
        $display("FAIL illegal_halt_cyc%0d obs=%h instret=%0d exp obs=%h instret=5",
                 i, obs, instret, ev(5,1,1, 0,0,0,0,0,0,0, 0,0,0,0));
      end
    end
  endtask

  task automatic test_timeout();
    // Fetch never answered: four waiting cycles, then trap with cause 3
    apply_reset();
    opcode = OP_ADDI;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); mem_ready = 1'b0; #1;
      tests_run++;
      if (i < 4 && obs !== ev(0,0,0, 1,0,1,0,0,0,0, 0,0,0,0)) begin
        tests_failed++;
        $display("FAIL timeout_wait%0d obs=%h exp=%h", i, obs, ev(0,0,0, 1,0,1,0,0,0,0, 0,0,0,0));
      end else if (i == 4 && obs !== ev(5,1,3, 0,0,0,0,0,0,0, 0,0,0,0)) begin
        tests_failed++;
        $display("FAIL timeout_trap obs=%h exp=%h", obs, ev(5,1,3, 0,0,0,0,0,0,0, 0,0,0,0));
      end
    end
    // mem_ready on the fourth waiting cycle beats expiry
    apply_reset();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); mem_ready = (i == 3); #1;
      if (i == 3) begin
        tests_run++;
        if (obs !== ev(0,0,0, 1,0,1,1,0,0,0, 0,0,0,0)) begin
          tests_failed++;
          $display("FAIL timeout_late_ready obs=%h exp=%h", obs, ev(0,0,0, 1,0,1,1,0,0,0, 0,0,0,0));
        end
      end else if (i == 4) begin
        tests_run++;
        if (obs !== ev(1,0,0, 0,0,0,0,0,0,0, 0,0,0,1)) begin
          tests_failed++;
          $display("FAIL timeout_to_decode obs=%h exp=%h", obs, ev(1,0,0, 0,0,0,0,0,0,0, 0,0,0,1));
        end
      end
    end
  endtask

  task automatic test_system();
    apply_reset();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); opcode = OP_SYS; mem_ready = 1'b1; #1;
    end
    tests_run++;
    if (obs !== ev(5,1,2, 0,0,0,0,0,0,0, 0,0,0,0) || instret !== 32'd0) begin
      tests_failed++;
      $display("FAIL system_trap obs=%h instret=%0d exp obs=%h instret=0",
               obs, instret, ev(5,1,2, 0,0,0,0,0,0,0, 0,0,0,0));
    end
  endtask

  task automatic test_reset_mid_store();
    logic [20:0] exp_v [4];
    apply_reset();
    exp_v[0] = ev(0,0,0, 1,0,1,1,0,0,0, 0,0,0,0);
    exp_v[1] = ev(1,0,0, 0,0,0,0,0,0,0, 0,0,0,2);
    exp_v[2] = ev(2,0,0, 0,0,0,0,0,0,0, 0,1,0,2);
    exp_v[3] = ev(3,0,0, 1,1,0,0,1,0,0, 0,0,0,2);
    // Zero-wait store completes in four cycles
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); opcode = OP_SW; mem_ready = 1'b1; #1;
      tests_run++;
      if (obs !== exp_v[i]) begin
        tests_failed++;
        $display("FAIL store_cyc%0d obs=%h exp=%h", i, obs, exp_v[i]);
      end
    end
    @(posedge clk); #2;
    tests_run++;
    if (instret !== 32'd1 || state_o !== 3'd0) begin
      tests_failed++;
      $display("FAIL store_retire instret=%0d state=%0d exp 1/0", instret, state_o);
    end
    // Second store stalls in MEM; reset lands during the wait
    exp_v[3] = ev(3,0,0, 1,1,0,0,0,0,0, 0,0,0,2);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); mem_ready = (i < 3); #1;
      tests_run++;
      if (obs !== exp_v[i]) begin
        tests_failed++;
        $display("FAIL store_wait_cyc%0d obs=%h exp=%h", i, obs, exp_v[i]);
      end
    end
    #1 rst_n = 1'b0;
    #1;
    tests_run++;
    if (obs !== 21'd0 || instret !== 32'd0) begin
      tests_failed++;
      $display("FAIL reset_mid_store obs=%h instret=%0d exp obs=0 instret=0", obs, instret);
    end
    @(negedge clk);
    @(posedge clk); #2;
    rst_n = 1'b1;
    @(negedge clk); mem_ready = 1'b0; #1;
    tests_run++;
    if (obs !== ev(0,0,0, 1,0,1,0,0,0,0, 0,0,0,0)) begin
      tests_failed++;
      $display("FAIL reset_release_fetch obs=%h exp=%h", obs, ev(0,0,0, 1,0,1,0,0,0,0, 0,0,0,0));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; opcode = 7'd0; br_taken = 1'b0; mem_ready = 1'b0;
    test_reset();
    test_addi();
    test_load_wait();
    test_branch();
    test_jal();
    test_illegal();
    test_timeout();
    test_system();
    test_reset_mid_store();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
